// File: rtl/integ_pkg.sv
// Shared register map and CTRL/STATUS bit positions for the integration bank.
// INTEG_IRQ_EN adds the storable CTRL.IRQ_EN bit.
package integ_pkg;
  typedef enum logic [1:0] {
    REG_STEP   = 2'd0,
    REG_ACC    = 2'd1,
    REG_CTRL   = 2'd2,
    REG_STATUS = 2'd3
  } reg_e;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_SAT    = 1;
  localparam int CTRL_IRQ_EN = 3;
  localparam int STATUS_OVF  = 0;

`ifdef INTEG_IRQ_EN
  localparam logic [3:0] CTRL_MASK = 4'b1011;
`else
  localparam logic [3:0] CTRL_MASK = 4'b0011;
`endif
endpackage

// File: rtl/integ_channel.sv
// One accumulator channel: STEP/ACC/CTRL/STATUS registers plus wrap/saturate add.
// CTRL.IRQ_EN is only stored when INTEG_IRQ_EN is defined (via CTRL_MASK).
module integ_channel
  import integ_pkg::*;
#(
  parameter int N = 32
) (
  input  logic                clk,
  input  logic                srst_n,
  input  logic                wr_en,
  input  logic [1:0]          wr_reg,
  input  logic [N-1:0]        wr_data,
  output logic [N-1:0]        acc,
  output logic [3:0][N-1:0]   rd_data,
  output logic                ovf
);
  logic [N-1:0] step_q, step_d, acc_q, acc_d;
  logic [3:0]   ctrl_q, ctrl_d;
  logic         ovf_q, ovf_d;
  logic [N:0]   sum;
  logic         acc_wr;

  always_comb begin
    step_d = step_q;
    acc_d  = acc_q;
    ctrl_d = ctrl_q;
    ovf_d  = ovf_q;
    sum    = {1'b0, acc_q} + {1'b0, step_q};
    acc_wr = wr_en && (wr_reg == REG_ACC);
    if (wr_en) begin
      case (reg_e'(wr_reg))
        REG_STEP:   step_d = wr_data;
        REG_ACC:    acc_d  = wr_data;
        REG_CTRL:   ctrl_d = wr_data[3:0] & CTRL_MASK;
        REG_STATUS: if (wr_data[STATUS_OVF]) ovf_d = 1'b0;
        default: ;
      endcase
    end
    // Applied after the W1C so a fresh overflow wins over the clear.
    if (ctrl_q[CTRL_EN] && !acc_wr) begin
      if (sum[N]) begin
        ovf_d = 1'b1;
        acc_d = ctrl_q[CTRL_SAT] ? '1 : sum[N-1:0];
      end else begin
        acc_d = sum[N-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!srst_n) begin
      step_q <= '0;
      acc_q  <= '0;
      ctrl_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      step_q <= step_d;
      acc_q  <= acc_d;
      ctrl_q <= ctrl_d;
      ovf_q  <= ovf_d;
    end
  end

  always_comb begin
    rd_data                        = '0;
    rd_data[REG_STEP]              = step_q;
    rd_data[REG_ACC]               = acc_q;
    rd_data[REG_CTRL][3:0]         = ctrl_q;
    rd_data[REG_STATUS][STATUS_OVF] = ovf_q;
  end

  assign acc = acc_q;
  assign ovf = ovf_q;
endmodule

// File: rtl/integration_bank.sv
// CH-channel accumulator bank behind an Avalon-MM slave, accumulators on coe_R.
// Optional ins_irq output when INTEG_IRQ_EN is defined.
module integration_bank
  import integ_pkg::*;
#(
  parameter int N  = 32,
  parameter int CH = 4
) (
  input  logic            csi_clk,
  input  logic            rsi_srst_n,
  input  logic [7:0]      avs_s0_address,
  input  logic            avs_s0_write,
  input  logic [N-1:0]    avs_s0_writedata,
  input  logic            avs_s0_read,
  output logic [N-1:0]    avs_s0_readdata,
  output logic [CH*N-1:0] coe_R
`ifdef INTEG_IRQ_EN
  ,
  output logic            ins_irq
`endif
);
  logic [5:0]                ch_idx;
  logic [1:0]                reg_idx;
  logic [CH-1:0][N-1:0]      acc_w;
  logic [CH-1:0][3:0][N-1:0] rd_w;
  logic [CH-1:0]             ovf_w;
  logic [N-1:0]              rdata_q, rdata_d;

  assign ch_idx  = avs_s0_address[7:2];
  assign reg_idx = avs_s0_address[1:0];

  for (genvar i = 0; i < CH; i++) begin : g_ch
    integ_channel #(.N(N)) u_ch (
      .clk     (csi_clk),
      .srst_n  (rsi_srst_n),
      .wr_en   (avs_s0_write && (int'(ch_idx) == i)),
      .wr_reg  (reg_idx),
      .wr_data (avs_s0_writedata),
      .acc     (acc_w[i]),
      .rd_data (rd_w[i]),
      .ovf     (ovf_w[i])
    );
  end

  assign coe_R = acc_w;

  // Out-of-range channels match no instance and read back as zero.
  always_comb begin
    rdata_d = rdata_q;
    if (avs_s0_read) begin
      rdata_d = '0;
      for (int i = 0; i < CH; i++)
        if (int'(ch_idx) == i) rdata_d = rd_w[i][reg_idx];
    end
  end

  always_ff @(posedge csi_clk) begin
    if (!rsi_srst_n) rdata_q <= '0;
    else             rdata_q <= rdata_d;
  end

  assign avs_s0_readdata = rdata_q;

`ifdef INTEG_IRQ_EN
  logic irq_q, irq_d;

  always_comb begin
    irq_d = 1'b0;
    for (int i = 0; i < CH; i++)
      irq_d = irq_d | (ovf_w[i] & rd_w[i][REG_CTRL][CTRL_IRQ_EN]);
  end

  always_ff @(posedge csi_clk) begin
    if (!rsi_srst_n) irq_q <= 1'b0;
    else             irq_q <= irq_d;
  end

  assign ins_irq = irq_q;
`else
  logic unused_ovf;
  assign unused_ovf = ^ovf_w;
`endif
endmodule
